// File: rtl/pio_pkg.sv
// pio_pkg: shared constants for the multi-pin GPIO block.
//   - Avalon-MM word addresses of the register map
//   - edge-capture mode selectors
//   - edge_hit(): edge-detect helper used by every per-bit input path
package pio_pkg;

    localparam logic [2:0] PIO_ADDR_DIR      = 3'd0;
    localparam logic [2:0] PIO_ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] PIO_ADDR_DATA_IN  = 3'd2;
    localparam logic [2:0] PIO_ADDR_IRQ_MASK = 3'd3;
    localparam logic [2:0] PIO_ADDR_EDGE_CAP = 3'd4;
    localparam logic [2:0] PIO_ADDR_OUT_SET  = 3'd5;
    localparam logic [2:0] PIO_ADDR_OUT_CLR  = 3'd6;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic logic edge_hit(input int kind, input logic cur, input logic prev);
        logic hit;
        case (kind)
            EDGE_FALL: hit = ~cur & prev;
            EDGE_ANY:  hit = cur ^ prev;
            default:   hit = cur & ~prev;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: one-bit input path for the GPIO block.
//   clk, reset : clock, async active-high reset
//   pin_i      : raw (asynchronous) pin value
//   sync_o     : synchronized pin value (last synchronizer stage)
//   edge_o     : single-cycle pulse when the selected edge is seen
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic sync_o,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], pin_i};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];
    assign edge_o = edge_hit(EDGE_TYPE, chain_q[SYNC_STAGES-1], prev_q);

endmodule

// File: rtl/pio_gpio_irq.sv
// pio_gpio_irq: WIDTH-pin Avalon-MM GPIO with edge capture and level irq.
//   clk, reset        : sole clock, async active-high reset
//   address/write/read/writedata : Avalon-MM slave, no waitrequest
//   readdata          : registered read data, 1-cycle latency
//   irq               : OR of (EDGE_CAP & IRQ_MASK)
//   pio_pin           : tri-state pins, driven where DIR=1
module pio_gpio_irq
    import pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             write,
    input  logic             read,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] pio_pin
);

    logic [WIDTH-1:0] dir_q,  dir_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] ecap_clr;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_det;

    // Upper writedata bits are don't-care when WIDTH < 32.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wdata = writedata[WIDTH-1:0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign pio_pin[i] = dir_q[i] ? dout_q[i] : 1'bz;

        // Samples the pin even when this block drives it.
        pio_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_TYPE   (EDGE_TYPE)
        ) u_sync_edge (
            .clk    (clk),
            .reset  (reset),
            .pin_i  (pio_pin[i]),
            .sync_o (sync_in[i]),
            .edge_o (edge_det[i])
        );
    end

    always_comb begin
        dir_d    = dir_q;
        dout_d   = dout_q;
        mask_d   = mask_q;
        ecap_clr = '0;
        if (write) begin
            case (address)
                PIO_ADDR_DIR:      dir_d    = wdata;
                PIO_ADDR_DATA_OUT: dout_d   = wdata;
                PIO_ADDR_IRQ_MASK: mask_d   = wdata;
                PIO_ADDR_EDGE_CAP: ecap_clr = wdata;
                PIO_ADDR_OUT_SET:  dout_d   = dout_q | wdata;
                PIO_ADDR_OUT_CLR:  dout_d   = dout_q & ~wdata;
                default: ;
            endcase
        end
        // A new edge wins over a simultaneous W1C of the same bit.
        ecap_d = (ecap_q & ~ecap_clr) | edge_det;
    end

    // Read mux sees pre-write register values, so read+write to the same
    // address returns the old contents.
    always_comb begin
        rdata_d = rdata_q;
        if (read) begin
            rdata_d = '0;
            case (address)
                PIO_ADDR_DIR:      rdata_d[WIDTH-1:0] = dir_q;
                PIO_ADDR_DATA_OUT: rdata_d[WIDTH-1:0] = dout_q;
                PIO_ADDR_DATA_IN:  rdata_d[WIDTH-1:0] = sync_in;
                PIO_ADDR_IRQ_MASK: rdata_d[WIDTH-1:0] = mask_q;
                PIO_ADDR_EDGE_CAP: rdata_d[WIDTH-1:0] = ecap_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q   <= '0;
            dout_q  <= '0;
            mask_q  <= '0;
            ecap_q  <= '0;
            rdata_q <= '0;
        end else begin
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            mask_q  <= mask_d;
            ecap_q  <= ecap_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(ecap_q & mask_q);

endmodule

// File: tb/tb_pio_gpio_irq.sv
module tb_pio_gpio_irq;
    import pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] writedata = '0;
    wire  [31:0] readdata;
    wire         irq;
    wire  [7:0]  pio_pin;

    logic [7:0]  ext_en = '0;
    logic [7:0]  ext_val = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pio_gpio_irq #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (EDGE_RISE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .write     (write),
        .read      (read),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .pio_pin   (pio_pin)
    );

    // Undriven pins read 0, so "high-Z" shows up as 0 on the net.
    for (genvar g = 0; g < 8; g++) begin : g_pin
        pulldown pd (pio_pin[g]);
        assign pio_pin[g] = ext_en[g] ? ext_val[g] : 1'bz;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(posedge clk);
        #1;
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        @(posedge clk);
        #1;
        read    = 1'b0;
        d       = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        tick(2);
        total++;
        if (irq !== 1'b0 || pio_pin !== 8'h00 || readdata !== 32'h0) begin
            bad++;
            $display("FAIL in_reset: irq=%b pins=%h rd=%h want 0/00/0", irq, pio_pin, readdata);
        end
        reset = 1'b0;
        tick(1);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            total++;
            if (rd !== 32'h0) begin
                bad++;
                $display("FAIL reset_read addr%0d: got %h want 00000000", a, rd);
            end
        end
        total++;
        if (pio_pin !== 8'h00) begin
            bad++;
            $display("FAIL reset_pins: got %h want 00", pio_pin);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
    endtask

    task automatic test_dir_out();
        logic [31:0] rd;
        bus_write(PIO_ADDR_DIR, 32'h0F);
        bus_write(PIO_ADDR_DATA_OUT, 32'hFFFF_FFA5);
        total++;
        if (pio_pin !== 8'h05) begin
            bad++;
            $display("FAIL drive_a5: pins=%h want 05", pio_pin);
        end
        bus_read(PIO_ADDR_DIR, rd);
        total++;
        if (rd !== 32'h0F) begin
            bad++;
            $display("FAIL dir_read: got %h want 0000000f", rd);
        end
        bus_read(PIO_ADDR_DATA_OUT, rd);
        total++;
        if (rd !== 32'hA5) begin
            bad++;
            $display("FAIL dout_read: got %h want 000000a5", rd);
        end
        bus_write(PIO_ADDR_OUT_SET, 32'h02);
        total++;
        if (pio_pin !== 8'h07) begin
            bad++;
            $display("FAIL set_pins: got %h want 07", pio_pin);
        end
        bus_read(PIO_ADDR_DATA_OUT, rd);
        total++;
        if (rd !== 32'hA7) begin
            bad++;
            $display("FAIL out_set: got %h want 000000a7", rd);
        end
        bus_write(PIO_ADDR_OUT_CLR, 32'h81);
        bus_read(PIO_ADDR_DATA_OUT, rd);
        total++;
        if (rd !== 32'h26) begin
            bad++;
            $display("FAIL out_clr: got %h want 00000026", rd);
        end
        total++;
        if (pio_pin !== 8'h06) begin
            bad++;
            $display("FAIL clr_pins: got %h want 06", pio_pin);
        end
        bus_read(PIO_ADDR_OUT_SET, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL out_set_read: got %h want 0", rd);
        end
        bus_read(PIO_ADDR_OUT_CLR, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL out_clr_read: got %h want 0", rd);
        end
        bus_write(PIO_ADDR_DATA_IN, 32'hFF);
        bus_write(3'd7, 32'hFF);
        bus_read(3'd7, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL rsvd_read: got %h want 0", rd);
        end
        bus_read(PIO_ADDR_DATA_IN, rd);
        total++;
        if (rd !== 32'h06) begin
            bad++;
            $display("FAIL din_own: got %h want 00000006", rd);
        end
        // Own driven rises on bits 0,2 (A5) and 1 (OUT_SET) are captured.
        bus_read(PIO_ADDR_EDGE_CAP, rd);
        total++;
        if (rd !== 32'h07 || irq !== 1'b0) begin
            bad++;
            $display("FAIL own_edges: cap=%h irq=%b want 00000007/0", rd, irq);
        end
        bus_write(PIO_ADDR_EDGE_CAP, 32'h05);
        bus_read(PIO_ADDR_EDGE_CAP, rd);
        total++;
        if (rd !== 32'h02) begin
            bad++;
            $display("FAIL w1c_partial: got %h want 00000002", rd);
        end
        bus_write(PIO_ADDR_EDGE_CAP, 32'hFF);
    endtask

    task automatic test_data_in();
        logic [31:0] rd;
        ext_en  = 8'hF0;
        ext_val = 8'h30;
        bus_read(PIO_ADDR_DATA_IN, rd);
        total++;
        if (rd !== 32'h06) begin
            bad++;
            $display("FAIL din_t1: got %h want 00000006", rd);
        end
        bus_read(PIO_ADDR_DATA_IN, rd);
        total++;
        if (rd !== 32'h06) begin
            bad++;
            $display("FAIL din_t2: got %h want 00000006", rd);
        end
        bus_read(PIO_ADDR_DATA_IN, rd);
        total++;
        if (rd !== 32'h36) begin
            bad++;
            $display("FAIL din_t3: got %h want 00000036", rd);
        end
        tick(2);
        bus_read(PIO_ADDR_EDGE_CAP, rd);
        total++;
        if (rd !== 32'h30) begin
            bad++;
            $display("FAIL ext_edges: got %h want 00000030", rd);
        end
        bus_write(PIO_ADDR_EDGE_CAP, 32'hFF);
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        ext_val = 8'h00;
        tick(4);
        bus_write(PIO_ADDR_EDGE_CAP, 32'hFF);
        bus_write(PIO_ADDR_IRQ_MASK, 32'h10);
        ext_val = 8'h10;
        tick(2);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_early: got %b want 0", irq);
        end
        tick(1);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_latency: got %b want 1", irq);
        end
        bus_read(PIO_ADDR_EDGE_CAP, rd);
        total++;
        if (rd !== 32'h10) begin
            bad++;
            $display("FAIL cap_pin4: got %h want 00000010", rd);
        end
        bus_write(PIO_ADDR_EDGE_CAP, 32'h10);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_w1c: got %b want 0", irq);
        end
        ext_val = 8'h30;
        tick(4);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_masked: got %b want 0", irq);
        end
        bus_read(PIO_ADDR_EDGE_CAP, rd);
        total++;
        if (rd !== 32'h20) begin
            bad++;
            $display("FAIL cap_pin5: got %h want 00000020", rd);
        end
        bus_write(PIO_ADDR_IRQ_MASK, 32'h30);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_unmask: got %b want 1", irq);
        end
        bus_write(PIO_ADDR_IRQ_MASK, 32'h10);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_remask: got %b want 0", irq);
        end
        bus_write(PIO_ADDR_EDGE_CAP, 32'hFF);
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        ext_val = 8'h20;
        tick(4);
        ext_val = 8'h30;
        tick(3);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL coll_setup: irq=%b want 1", irq);
        end
        ext_val = 8'h20;
        tick(4);
        ext_val = 8'h30;
        tick(2);
        // W1C lands on the same edge that captures the new rise.
        bus_write(PIO_ADDR_EDGE_CAP, 32'h10);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL coll_irq: got %b want 1", irq);
        end
        bus_read(PIO_ADDR_EDGE_CAP, rd);
        total++;
        if (rd !== 32'h10) begin
            bad++;
            $display("FAIL coll_cap: got %h want 00000010", rd);
        end
        bus_write(PIO_ADDR_EDGE_CAP, 32'h10);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL coll_clear: got %b want 0", irq);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        address   = PIO_ADDR_DATA_OUT;
        writedata = 32'h55;
        write     = 1'b1;
        read      = 1'b1;
        tick(1);
        write     = 1'b0;
        read      = 1'b0;
        total++;
        if (readdata !== 32'h26) begin
            bad++;
            $display("FAIL rw_same: got %h want 00000026", readdata);
        end
        tick(3);
        total++;
        if (readdata !== 32'h26) begin
            bad++;
            $display("FAIL rd_hold: got %h want 00000026", readdata);
        end
        bus_read(PIO_ADDR_DATA_OUT, rd);
        total++;
        if (rd !== 32'h55) begin
            bad++;
            $display("FAIL rw_after: got %h want 00000055", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        ext_en  = 8'h00;
        ext_val = 8'h00;
        bus_write(PIO_ADDR_DIR, 32'hFF);
        bus_write(PIO_ADDR_DATA_OUT, 32'hFF);
        bus_write(PIO_ADDR_IRQ_MASK, 32'hFF);
        tick(4);
        bus_read(PIO_ADDR_DIR, rd);
        total++;
        if (pio_pin !== 8'hFF || irq !== 1'b1 || rd !== 32'hFF) begin
            bad++;
            $display("FAIL pre_reset: pins=%h irq=%b rd=%h want ff/1/000000ff", pio_pin, irq, rd);
        end
        reset = 1'b1;
        #1;
        total++;
        if (pio_pin !== 8'h00 || irq !== 1'b0 || readdata !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset: pins=%h irq=%b rd=%h want 00/0/0", pio_pin, irq, readdata);
        end
        tick(1);
        reset = 1'b0;
        bus_read(PIO_ADDR_EDGE_CAP, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL post_reset_cap: got %h want 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_dir_out();
        test_data_in();
        test_irq();
        test_w1c_collision();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pio_gpio_irq.md
# pio_gpio_irq

Parametrised Avalon-MM general-purpose I/O port with `WIDTH` independent tri-state pins. It has:
- per-bit direction and output registers;
- atomic set/clear of output bits;
- a metastability-hardened input path;
- edge capture with a maskable level interrupt.

It sits on the same Avalon-MM slave fabric as the existing single-pin PIO and replaces it wherever more than one pin or an interrupt is required.

## Interface
- `WIDTH`, 8: number of I/O pins, 1..32.
- `SYNC_STAGES`, 2: input synchronizer flops, 2..4.
- `EDGE_TYPE`, 0: capture mode, applied to all bits. 0 = rising, 1 = falling, 2 = any edge.
- `clk` input 1: sole clock.
- `reset` input 1: asynchronous, active-high reset.
- `address` input 3: Avalon-MM word address.
- `write` input 1: write strobe.
- `read` input 1: read strobe.
- `writedata` input 32: write data. Bits `[WIDTH-1:0]` are used; the rest are ignored.
- `readdata` output 32: registered read data. Bits above `WIDTH` read 0.
- `irq` output 1: level interrupt request.
- `pio_pin` inout WIDTH: tri-state pins.

## Operation
Register map:
- 0 `DIR`, RW: 1 = output, 0 = input, per bit.
- 1 `DATA_OUT`, RW: output data register.
- 2 `DATA_IN`, RO: synchronized pin values. Writes are ignored.
- 3 `IRQ_MASK`, RW: 1 enables the interrupt for that bit.
- 4 `EDGE_CAP`, R/W1C: sticky edge flags. Writing 1 clears the bit; writing 0 has no effect.
- 5 `OUT_SET`, WO: `DATA_OUT |= writedata`. Reads return 0.
- 6 `OUT_CLR`, WO: `DATA_OUT &= ~writedata`. Reads return 0.
- 7: reserved. Reads return 0; writes are ignored.

Pin drive:
- `pio_pin[i]` = `DATA_OUT[i]` when `DIR[i]` = 1, otherwise high-Z.
- The input path always samples the pin, including the block's own driven value.

Input path:
- A `SYNC_STAGES`-deep flop chain feeds the `DATA_IN` register (`sync_q`).
- One further flop holds `prev_q`.
- An edge is detected from `sync_q` vs `prev_q`:
  - rising: `sync_q & ~prev_q`;
  - falling: `~sync_q & prev_q`;
  - any: `sync_q ^ prev_q`.
- A detected edge sets the corresponding `EDGE_CAP` bit. This happens regardless of `DIR` and `IRQ_MASK`.

Interrupt:
- `irq` = OR-reduction of (`EDGE_CAP & IRQ_MASK`), driven directly from registers.
- `irq` stays high until software clears the flag or masks the bit.

Reset values (all 0): `DIR`, `DATA_OUT`, `IRQ_MASK`, `EDGE_CAP`, synchronizer and `prev_q` flops, `readdata`, `irq`. All pins are high-Z during and after reset.

Simultaneous events:
- Edge detected and W1C on the same `EDGE_CAP` bit in the same cycle: the set wins and the bit stays 1.
- `read` and `write` to the same address in the same cycle: `readdata` returns the pre-write value.
- `read` with no new `read` following: `readdata` holds its last value.

## Timing
- Read latency is 1 cycle: `readdata` is valid on the edge after `read` is sampled. There is no waitrequest.
- Write to `DIR`, `DATA_OUT`, `OUT_SET` or `OUT_CLR` affects `pio_pin` on the following edge.
- Pin change to visible in `DATA_IN`: `SYNC_STAGES` clocks.
- Pin edge to `EDGE_CAP` set and `irq` high: `SYNC_STAGES`+1 clocks.
- W1C write to `irq` deassertion: 1 clock, provided no other masked flag remains.
- Reset asserted mid-operation clears all state immediately. In-flight edges are lost; pins go high-Z at once.

## Structure
- Package `pio_pkg` holds:
  - the address constants `PIO_ADDR_DIR` through `PIO_ADDR_OUT_CLR`;
  - the edge-type localparams `EDGE_RISE`, `EDGE_FALL` and `EDGE_ANY`.
- Sub-module `pio_sync_edge` is one per-bit instance. It contains the synchronizer chain, `prev_q` and the edge-detect pulse, parametrised by `SYNC_STAGES` and `EDGE_TYPE`. The top level generates `WIDTH` instances.

## Test plan
- Reset, then read all 8 addresses -> every read returns 0, all pins Z, `irq` = 0.
- `WIDTH`=8:
  - write `DIR`=0x0F, `DATA_OUT`=0xA5 -> pins[3:0] = 0x5, pins[7:4] Z;
  - then `OUT_SET` 0x02 -> `DATA_OUT` = 0xA7;
  - then `OUT_CLR` 0x81 -> `DATA_OUT` = 0x26.
- External drive pins[7:4] = 0x3 at cycle T -> `DATA_IN`[7:4] reads 0x3 once the value is visible at T+2 (`SYNC_STAGES`=2).
- Rising mode, `IRQ_MASK`=0x10, pin4 rises -> `EDGE_CAP` = 0x10 and `irq` = 1 after 3 clocks. Write 0x10 to `EDGE_CAP` -> `irq` = 0 the next cycle.
- W1C of bit 4 in the same cycle a new edge on pin4 is detected -> `EDGE_CAP`[4] stays 1 and `irq` stays 1.
- Assert `reset` while `DIR`=0xFF and `irq`=1 -> pins Z, `irq` = 0 and `readdata` = 0 within the same cycle.
